axi_stream_fifo: RTL and testbench
==================================

AXI_STREAM_FIFO -- requirements
Module: axi_stream_fifo

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: payload width in bits, at least 1.
REQ-002 SHALL have parameter DEPTH, default 4: entry count, a power of two, at least 2.
REQ-003 SHALL have parameter AFULL_LVL, default 3: almost-full threshold, in the range 1..DEPTH.
REQ-004 SHALL have one clock and an asynchronous active-low reset, with ports as follows:
  aclk_i  input  1  sole clock; all state changes on its rising edge.
  aresetn_i  input  1  asynchronous reset, active low.
  valid_i  input  1  upstream data valid.
  ready_o  output  1  FIFO can accept a word.
  data_i  input  DWIDTH  upstream payload.
  valid_o  output  1  downstream data valid.
  ready_i  input  1  downstream can accept a word.
  data_o  output  DWIDTH  downstream payload.
  count_o  output  CW  current occupancy, where CW = clog2(DEPTH+1).
  full_o  output  1  occupancy equals DEPTH.
  empty_o  output  1  occupancy equals 0.
  afull_o  output  1  occupancy is at least AFULL_LVL.

Function
REQ-005 SHALL define a push as valid_i && ready_o at a rising edge, and a pop as valid_o && ready_i at a rising edge.
REQ-006 SHALL drive ready_o as !full_o, decoded from registered state only, with no combinational path from ready_i.
REQ-007 SHALL drive valid_o as !empty_o, decoded from registered state only, with no combinational path from valid_i.
REQ-008 SHALL drive data_o from the storage entry at the read pointer, with no combinational path from data_i.
REQ-009 SHALL have a first-word latency of 1 cycle: a word pushed into an empty FIFO at edge N has valid_o high starting right after edge N.
REQ-010 SHALL sustain one push and one pop per cycle indefinitely whenever 0 < count_o < DEPTH.
REQ-011 SHALL update count_o by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop or on neither.
REQ-012 SHALL, when empty, ignore ready_i; no pop occurs and no pointer moves.
REQ-013 SHALL, when full, hold ready_o low for the whole cycle, even if a pop occurs in that same cycle; ready_o returns high the cycle after the pop.
REQ-014 SHALL advance the write and read pointers modulo DEPTH, so index DEPTH-1 wraps to 0.
REQ-015 SHALL use pointers log2(DEPTH)+1 bits wide, with full and empty decoded from the pointer MSB and the pointer equality.
REQ-016 SHALL preserve order: words leave in exactly the order they were pushed, with no loss or duplication.
REQ-017 SHALL hold data_o and valid_o stable while valid_o is high and ready_i is low.
REQ-018 SHALL, with valid_i low, leave the storage contents and write pointer untouched.
REQ-019 SHALL generate afull_o, full_o and empty_o as registered decodes of count_o, consistent with it on every cycle.

Reset
REQ-020 SHALL, while aresetn_i is low, asynchronously force pointers to 0, count_o to 0, empty_o to 1, and full_o, afull_o and valid_o to 0.
REQ-021 SHALL, while aresetn_i is low, force ready_o to 0, and raise ready_o on the first rising edge after release.
REQ-022 SHALL NOT reset storage contents; data_o is don't-care while valid_o is low.
REQ-023 SHALL, on reset assertion mid-transfer, discard all stored words; no word is presented after release until a new push.

Structure
REQ-024 SHALL place the clog2 helper function and the default DWIDTH and DEPTH constants in the shared axi definitions package, used by all axi_* blocks.
REQ-025 SHALL implement the wrapping read and write pointers as one reusable sub-module, axi_ptr_cnt, instantiated twice.
REQ-026 SHALL implement storage as a flop array of DEPTH x DWIDTH, inferable as distributed RAM.

Verification
REQ-027 SHALL cover streaming (DEPTH=4, DWIDTH=8): valid_i and ready_i held at 1 for 20 cycles with incrementing data 0x00..0x13 -> data_o equals 0x00..0x13 in order, ready_o is never 0 after the first cycle, and count_o stays at 1.
REQ-028 SHALL cover fill and drain: push 0xA1..0xA4 with ready_i=0 -> count_o=4, full_o=1, afull_o=1 from count 3, ready_o=0; then ready_i=1 -> outputs 0xA1..0xA4 in order, ending with empty_o=1.
REQ-029 SHALL cover the full-with-pop case: with the FIFO full, valid_i=1 and ready_i=1 for one cycle -> no push occurs, count_o=3, and ready_o=1 on the next cycle.
REQ-030 SHALL cover idle gaps: valid_i toggling randomly at 50% with ready_i=1 -> output stream equals input stream, and valid_o is never high with count_o=0.
REQ-031 SHALL cover pointer wrap-around: 3 pushes then 3 pops, repeated 5 times -> pointers wrap correctly and data matches the scoreboard.
REQ-032 SHALL cover reset mid-transfer: aresetn_i pulsed low for 3 ns with count_o=2 -> valid_o=0 and count_o=0 immediately; after release, no stale word appears.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared definitions for the axi_* blocks: default payload/depth constants
// and the ceil-log2 helper used to size pointers and counters.
package axi_pkg;

  localparam int AXI_DWIDTH = 8;
  localparam int AXI_DEPTH  = 4;

  // Smallest r with (1 << r) >= value; 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_ptr_cnt.sv
// Wrapping FIFO pointer: one extra MSB beyond the index bits so that
// full and empty can be told apart when the indices are equal.
module axi_ptr_cnt
  import axi_pkg::*;
#(
  parameter int DEPTH = AXI_DEPTH,
  localparam int PW = clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_nxt_o,
  output logic [PW-2:0] idx_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // DEPTH is a power of two, so plain binary rollover of the low bits is
  // exactly modulo-DEPTH indexing.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + PW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr_nxt_o = ptr_d;
  assign idx_o     = ptr_q[PW-2:0];

endmodule

// File: rtl/axi_stream_fifo.sv
// Single-clock AXI-Stream style FIFO with registered status flags and
// registered ready/valid so no input reaches an output combinationally.
module axi_stream_fifo
  import axi_pkg::*;
#(
  parameter int DWIDTH    = AXI_DWIDTH,
  parameter int DEPTH     = AXI_DEPTH,
  parameter int AFULL_LVL = 3,
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic              aclk_i,
  input  logic              aresetn_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DWIDTH-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] data_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              afull_o
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  // Handshake: a word moves on a rising edge where valid and ready are both
  // high; valid_o/ready_o depend only on registered state, and a source
  // holding valid keeps its payload stable until ready is seen.
  logic push;
  logic pop;

  logic [PW-1:0] wr_nxt;
  logic [PW-1:0] rd_nxt;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          ready_q, ready_d;

  logic [DWIDTH-1:0] mem_q [DEPTH];

  assign push = valid_i && ready_q;
  assign pop  = !empty_q && ready_i;

  axi_ptr_cnt #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_i     (aclk_i),
    .rst_n_i   (aresetn_i),
    .inc_i     (push),
    .ptr_nxt_o (wr_nxt),
    .idx_o     (wr_idx)
  );

  axi_ptr_cnt #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_i     (aclk_i),
    .rst_n_i   (aresetn_i),
    .inc_i     (pop),
    .ptr_nxt_o (rd_nxt),
    .idx_o     (rd_idx)
  );

  // Flags are decoded from next-state pointers/count so the registered
  // copies always agree with count_o in the same cycle.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    empty_d = (wr_nxt == rd_nxt);
    afull_d = (count_d >= AFULL_C);
    ready_d = !full_d;
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      afull_q <= afull_d;
      ready_q <= ready_d;
    end
  end

  // Storage is deliberately left out of reset so it maps to LUT RAM.
  always_ff @(posedge aclk_i) begin
    if (push) mem_q[wr_idx] <= data_i;
  end

  assign ready_o = ready_q;
  assign valid_o = !empty_q;
  assign data_o  = mem_q[rd_idx];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign afull_o = afull_q;

endmodule

// File: tb/tb_axi_stream_fifo.sv
// Directed bench for axi_stream_fifo (DEPTH=4, DWIDTH=8, AFULL_LVL=3)
// with an occupancy model and an expected-data queue.
module tb_axi_stream_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;

  logic          aclk_i;
  logic          aresetn_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_i;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] data_o;
  logic [2:0]    count_o;
  logic          full_o;
  logic          empty_o;
  logic          afull_o;

  axi_stream_fifo #(.DWIDTH(DW), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .aclk_i    (aclk_i),
    .aresetn_i (aresetn_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_i    (data_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .count_o   (count_o),
    .full_o    (full_o),
    .empty_o   (empty_o),
    .afull_o   (afull_o)
  );

  // clock / reset
  initial begin
    aclk_i = 1'b0;
    forever #5 aclk_i = ~aclk_i;
  end

  // scoreboard and model state
  logic [DW-1:0] exp_q[$];
  int            m_cnt;
  logic          m_rdy;
  int            checks;
  int            failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"}, 32'(count_o), 32'(m_cnt));
    check({tag, ".empty"}, 32'(empty_o), 32'(m_cnt == 0));
    check({tag, ".full"},  32'(full_o),  32'(m_cnt == DEPTH));
    check({tag, ".afull"}, 32'(afull_o), 32'(m_cnt >= AFULL));
    check({tag, ".valid"}, 32'(valid_o), 32'(m_cnt != 0));
    check({tag, ".ready"}, 32'(ready_o), 32'(m_rdy));
  endtask

  // driver: apply one cycle of inputs, predict, then check after the edge
  task automatic cycle(input string tag, input logic vi, input logic [DW-1:0] di, input logic ri);
    logic m_push;
    logic m_pop;
    logic [DW-1:0] exp_d;
    valid_i = vi;
    data_i  = di;
    ready_i = ri;
    m_push = vi && m_rdy;
    m_pop  = (m_cnt > 0) && ri;
    if (m_pop) begin
      exp_d = exp_q.pop_front();
      check({tag, ".data"}, 32'(data_o), 32'(exp_d));
    end
    if (m_push) exp_q.push_back(di);
    @(posedge aclk_i);
    #1;
    m_cnt = m_cnt + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
    m_rdy = (m_cnt != DEPTH);
    check_status(tag);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 0;
    m_rdy = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    aresetn_i = 1'b0;
    valid_i   = 1'b0;
    ready_i   = 1'b0;
    data_i    = '0;
    model_reset();
    repeat (2) @(posedge aclk_i);
    #1;
    check_status("reset");
    aresetn_i = 1'b1;

    // Idle first edge after release: ready rises, nothing stored.
    cycle("release", 1'b0, 8'h00, 1'b0);
    check("release.ready_hi", 32'(ready_o), 32'd1);

    // Streaming: occupancy settles at 1 with one push and one pop per cycle.
    for (int i = 0; i < 20; i++) begin
      cycle("stream", 1'b1, DW'(i), 1'b1);
      check("stream.count1", 32'(count_o), 32'd1);
    end
    cycle("stream_tail", 1'b0, 8'h00, 1'b1);
    check("stream_tail.empty", 32'(empty_o), 32'd1);

    // Fill to full with the sink stalled.
    cycle("fill", 1'b1, 8'hA1, 1'b0);
    cycle("fill", 1'b1, 8'hA2, 1'b0);
    check("fill.afull_below", 32'(afull_o), 32'd0);
    cycle("fill", 1'b1, 8'hA3, 1'b0);
    check("fill.afull_at3", 32'(afull_o), 32'd1);
    cycle("fill", 1'b1, 8'hA4, 1'b0);
    check("fill.full", 32'(full_o), 32'd1);
    check("fill.ready_lo", 32'(ready_o), 32'd0);
    // Stall while full: output word must hold, the extra word is refused.
    cycle("stall", 1'b1, 8'hEE, 1'b0);
    check("stall.data_hold", 32'(data_o), 32'hA1);

    // Drain.
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 8'h00, 1'b1);
    check("drain.empty", 32'(empty_o), 32'd1);
    // Pop attempt while empty must not disturb anything.
    cycle("empty_pop", 1'b0, 8'h00, 1'b1);

    // Full with simultaneous push attempt and pop.
    for (int i = 0; i < 4; i++) cycle("refill", 1'b1, DW'(8'hB0 + i), 1'b0);
    cycle("full_pop", 1'b1, 8'hCC, 1'b1);
    check("full_pop.count3", 32'(count_o), 32'd3);
    check("full_pop.ready_next", 32'(ready_o), 32'd1);
    for (int i = 0; i < 3; i++) cycle("full_pop_drain", 1'b0, 8'h00, 1'b1);

    // Idle gaps on the source with a free-running sink.
    for (int i = 0; i < 30; i++)
      cycle("gaps", 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)), 1'b1);
    cycle("gaps_tail", 1'b0, 8'h00, 1'b1);

    // Wrap-around: 3 in, 3 out, five times over a 4-entry ring.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) cycle("wrap_in", 1'b1, DW'(8'h10 * r + i), 1'b0);
      for (int i = 0; i < 3; i++) cycle("wrap_out", 1'b0, 8'h00, 1'b1);
    end

    // Reset mid-transfer with two words held.
    cycle("mid", 1'b1, 8'h55, 1'b0);
    cycle("mid", 1'b1, 8'h66, 1'b0);
    check("mid.count2", 32'(count_o), 32'd2);
    valid_i = 1'b0;
    #2;
    aresetn_i = 1'b0;
    model_reset();
    #1;
    check_status("mid_rst");
    #2;
    aresetn_i = 1'b1;
    @(posedge aclk_i);
    #1;
    m_rdy = 1'b1;
    check_status("post_rst");
    for (int i = 0; i < 3; i++) cycle("post_rst_idle", 1'b0, 8'h00, 1'b1);
    cycle("post_rst_push", 1'b1, 8'h77, 1'b0);
    check("post_rst_push.data", 32'(data_o), 32'h77);
    cycle("post_rst_pop", 1'b0, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
